uart_rx_cfg: RTL and testbench
==============================

Name: uart_rx_cfg

Overview:
Parametrised, oversampling UART receiver. It is the successor to the fixed 4x, 6–8-bit receiver.
- Adds an input synchroniser, centre-of-bit majority sampling and false-start rejection.
- Data length, parity and stop-bit count are selected at run time.
- Reports per-frame framing and parity errors and detects overrun.
- Delivers each byte to the host side of the UART through a valid/ready handshake.

Parameters:
OVERSAMPLE, 16, Tick pulses per bit period; even, >= 8.
MAX_BITS, 9, widest supported data field; 5..9.
SYNC_STAGES, 2, flip-flop stages on Rx before use; >= 2.

Ports:
Clk  input  1  system clock; all logic on rising edge.
Rst_n  input  1  synchronous, active-low reset.
Tick  input  1  one-Clk-wide enable pulse at OVERSAMPLE x baud.
RxEn  input  1  receiver enable.
Rx  input  1  asynchronous serial line; idles high.
NBits  input  4  data bits per frame, 5..MAX_BITS.
ParityMode  input  2  00 none, 01 even, 10 odd, 11 none.
StopBits  input  1  0 = one stop bit, 1 = two stop bits.
RxData  output  MAX_BITS  received word, right-justified, LSB first on the line, unused MSBs 0.
RxValid  output  1  RxData and error flags are valid.
RxReady  input  1  consumer accepts the word when RxValid & RxReady.
FrameErr  output  1  stop bit sampled low for this word.
ParityErr  output  1  parity mismatch for this word.
Overrun  output  1  a frame was lost while RxValid was pending.
Busy  output  1  FSM not in IDLE.

Behaviour:
- Reset (Rst_n = 0 at a Clk edge):
  - FSM goes to IDLE; all counters cleared; synchroniser loaded with 1.
  - Outputs: RxData = 0, RxValid = 0, FrameErr = 0, ParityErr = 0, Overrun = 0, Busy = 0.
  - Reset in mid-frame discards the partial frame.
- Synchroniser: Rx passes through SYNC_STAGES flops, giving rs. All sampling uses rs.
- Timing: FSM state and tick counter change only on Clk edges where Tick = 1. The exception is IDLE start detection, which is evaluated every Clk.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - Move to START when RxEn = 1 and a falling edge of rs is seen (previous rs = 1, current rs = 0).
  - On entry to START: tick counter = 0; NBits, ParityMode and StopBits are latched for the whole frame.
- Latched NBits is clamped: values < 5 become 5; values > MAX_BITS become MAX_BITS.
- Majority sampling: within each bit, rs is sampled on ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 (counted from the start edge for START, from the bit boundary otherwise). The bit value is the 2-of-3 majority.
- START:
  - At tick OVERSAMPLE/2+1, if the majority is 1: false start; return to IDLE with no output.
  - Otherwise stay until tick OVERSAMPLE-1, then go to DATA.
- DATA:
  - Each bit lasts OVERSAMPLE ticks.
  - Each majority bit shifts into the shift register, LSB first.
  - After the latched NBits bits, go to PARITY if ParityMode is 01 or 10, else go to STOP.
- PARITY: one bit period.
  - Even: the XOR of the data bits and the parity bit must be 0.
  - Odd: that XOR must be 1.
  - Mismatch sets the internal parity-error flag.
- STOP: one or two bit periods per the latched StopBits.
  - Any stop bit with majority 0 sets the internal frame-error flag.
  - On the tick where the last stop bit's final sample is taken, the FSM goes to IDLE immediately. This allows back-to-back frames; the next start edge is detected from then on.
- Delivery (frame completion):
  - On the Clk after the completing Tick, the word is loaded: RxData = data zero-extended to MAX_BITS, FrameErr/ParityErr = internal flags, RxValid = 1.
  - Latency: RxValid rises 1 Clk after the Tick carrying the final stop sample.
- Handshake:
  - RxValid, RxData and both error flags hold until RxValid & RxReady.
  - Without a new completion, RxValid deasserts on the next Clk after acceptance.
  - A completion arriving in the same Clk as an acceptance loads the new word; RxValid stays 1 and Overrun is not set.
  - A completion while RxValid = 1 and RxReady = 0: the new word is dropped, the old word is kept, Overrun is set.
- Overrun is sticky. It clears on the next accepted handshake, so the consumer sees it together with the word that preceded the loss.
- RxEn:
  - RxEn = 0 while in START, DATA, PARITY or STOP aborts the frame to IDLE with no output.
  - RxEn has no effect on a word already held in RxValid.
- Break condition (line held low for the whole frame): the word is delivered with RxData = 0 and FrameErr = 1. Then no new start is accepted until rs has been seen high.
- Busy = 1 whenever state != IDLE.

Test Plan:
- OVERSAMPLE = 16, 8N1, line carries 0xA5, RxReady = 1 → one RxValid pulse exactly 1 Clk after the final stop tick; RxData = 0x0A5, FrameErr = 0, ParityErr = 0.
- 7E1, byte 0x41 sent with parity bit 1 (wrong) → RxData = 0x041, ParityErr = 1. The same byte with parity 0 gives ParityErr = 0. 9O2, 0x1FF with correct parity → RxData = 0x1FF, no errors.
- Two stop bits with the second held low → FrameErr = 1, data intact. Line low for a full 8N1 frame → RxData = 0, FrameErr = 1, and no further frame until the line returns high.
- Rx low glitch of 5 ticks then high → no RxValid, Busy returns to 0 at tick 9.
- Single-tick mid-bit glitch inside a data bit → the bit value is unchanged (majority vote).
- RxReady = 0, two back-to-back frames 0x11 then 0x22 → RxData stays 0x011 and Overrun = 1. Then assert RxReady for one Clk → the word is accepted, RxValid = 0, Overrun = 0.
- Rst_n = 0 for one Clk in the middle of the DATA state → all outputs 0, state IDLE, next frame 0x3C received correctly.
- RxEn dropped during DATA → no output.
- NBits = 3 → treated as 5.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: oversampling UART receiver with run-time frame format.
//
// Rx is passed through a SYNC_STAGES-deep synchroniser. A falling edge seen in
// IDLE starts a frame. Each bit is decided by a 2-of-3 majority of the
// synchronised line, sampled around the bit centre. A start bit that reads
// high at its centre is rejected. Data length, parity mode and stop-bit count
// are captured when the start edge is accepted and held for the whole frame.
// Completed words are offered on a valid/ready handshake. A word that
// completes while the previous one is still unaccepted is dropped and
// flagged as an overrun.
//
// Ports:
//   Clk        system clock, rising edge
//   Rst_n      synchronous active-low reset
//   Tick       one-Clk enable pulse at OVERSAMPLE x baud
//   RxEn       receiver enable; dropping it mid-frame abandons the frame
//   Rx         asynchronous serial input, idles high
//   NBits      data bits per frame (clamped to 5..MAX_BITS)
//   ParityMode 00/11 none, 01 even, 10 odd
//   StopBits   0 one stop bit, 1 two stop bits
//   RxData     received word, right-justified, zero-extended
//   RxValid    RxData and error flags are valid
//   RxReady    consumer takes the word when RxValid & RxReady
//   FrameErr   a stop bit of this word was sampled low
//   ParityErr  parity mismatch on this word
//   Overrun    sticky: a frame was lost while a word was pending
//   Busy       receiver is inside a frame
module uart_rx_cfg #(
    parameter int OVERSAMPLE  = 16,
    parameter int MAX_BITS    = 9,
    parameter int SYNC_STAGES = 2
) (
    input  logic                Clk,
    input  logic                Rst_n,
    input  logic                Tick,
    input  logic                RxEn,
    input  logic                Rx,
    input  logic [3:0]          NBits,
    input  logic [1:0]          ParityMode,
    input  logic                StopBits,
    output logic [MAX_BITS-1:0] RxData,
    output logic                RxValid,
    input  logic                RxReady,
    output logic                FrameErr,
    output logic                ParityErr,
    output logic                Overrun,
    output logic                Busy
);

    localparam int            CW     = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] ZERO   = {CW{1'b0}};
    localparam logic [CW-1:0] ONE    = CW'(1);
    localparam logic [CW-1:0] T_S0   = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] T_S1   = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] T_S2   = CW'(OVERSAMPLE / 2 + 1);
    localparam logic [CW-1:0] T_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [3:0]    MAXB4  = 4'(MAX_BITS);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // 2-of-3 majority vote
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // XOR reduction of the received data field (unused MSBs are zero)
    function automatic logic parity_of(input logic [MAX_BITS-1:0] d);
        return ^d;
    endfunction

    // Bound the requested data length to what the shift register supports
    function automatic logic [3:0] clamp_nbits(input logic [3:0] n);
        logic [3:0] r;
        if (n < 4'd5) begin
            r = 4'd5;
        end else if (n > MAXB4) begin
            r = MAXB4;
        end else begin
            r = n;
        end
        return r;
    endfunction

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   rs_prev_r;
    state_t                 state_r;
    logic [CW-1:0]          tick_cnt_r;
    logic [3:0]             bit_cnt_r;
    logic                   stop_cnt_r;
    logic [1:0]             samp_r;
    logic [MAX_BITS-1:0]    shreg_r;
    logic [3:0]             nbits_r;
    logic [1:0]             pmode_r;
    logic                   two_stop_r;
    logic                   par_err_r;
    logic                   frm_err_r;
    logic                   done_r;
    logic                   busy_r;

    logic rs_s;
    logic start_edge_s;
    logic maj_s;

    assign rs_s         = sync_r[SYNC_STAGES-1];
    // Requiring a previous high sample means a line stuck low after a break
    // cannot start a new frame until it has returned high.
    assign start_edge_s = rs_prev_r & ~rs_s;
    // Valid on the third sample tick: two stored samples plus the live one
    assign maj_s        = maj3(samp_r[1], samp_r[0], rs_s);
    assign Busy         = busy_r;

    // Rx synchroniser and previous-sample register for edge detection
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            sync_r    <= {SYNC_STAGES{1'b1}};
            rs_prev_r <= 1'b1;
        end else begin
            sync_r    <= {sync_r[SYNC_STAGES-2:0], Rx};
            rs_prev_r <= rs_s;
        end
    end

    // Frame FSM: start detect every Clk, everything else advances on Tick
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_r    <= S_IDLE;
            tick_cnt_r <= ZERO;
            bit_cnt_r  <= 4'd0;
            stop_cnt_r <= 1'b0;
            samp_r     <= 2'b00;
            shreg_r    <= {MAX_BITS{1'b0}};
            nbits_r    <= 4'd5;
            pmode_r    <= 2'b00;
            two_stop_r <= 1'b0;
            par_err_r  <= 1'b0;
            frm_err_r  <= 1'b0;
            done_r     <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (RxEn && start_edge_s) begin
                        state_r    <= S_START;
                        busy_r     <= 1'b1;
                        tick_cnt_r <= ZERO;
                        bit_cnt_r  <= 4'd0;
                        stop_cnt_r <= 1'b0;
                        shreg_r    <= {MAX_BITS{1'b0}};
                        nbits_r    <= clamp_nbits(NBits);
                        pmode_r    <= ParityMode;
                        two_stop_r <= StopBits;
                        par_err_r  <= 1'b0;
                        frm_err_r  <= 1'b0;
                    end
                end
                default: begin
                    if (Tick) begin
                        if (!RxEn) begin
                            state_r    <= S_IDLE;
                            busy_r     <= 1'b0;
                            tick_cnt_r <= ZERO;
                        end else begin
                            if (tick_cnt_r == T_S0) samp_r[0] <= rs_s;
                            if (tick_cnt_r == T_S1) samp_r[1] <= rs_s;
                            tick_cnt_r <= (tick_cnt_r == T_LAST) ? ZERO : tick_cnt_r + ONE;
                            case (state_r)
                                S_START: begin
                                    if (tick_cnt_r == T_S2 && maj_s) begin
                                        state_r    <= S_IDLE;
                                        busy_r     <= 1'b0;
                                        tick_cnt_r <= ZERO;
                                    end else if (tick_cnt_r == T_LAST) begin
                                        state_r <= S_DATA;
                                    end
                                end
                                S_DATA: begin
                                    if (tick_cnt_r == T_S2) begin
                                        for (int i = 0; i < MAX_BITS; i++) begin
                                            if (bit_cnt_r == 4'(i)) shreg_r[i] <= maj_s;
                                        end
                                    end
                                    if (tick_cnt_r == T_LAST) begin
                                        if (bit_cnt_r == nbits_r - 4'd1) begin
                                            bit_cnt_r <= 4'd0;
                                            if (pmode_r == 2'b01 || pmode_r == 2'b10) begin
                                                state_r <= S_PARITY;
                                            end else begin
                                                state_r <= S_STOP;
                                            end
                                        end else begin
                                            bit_cnt_r <= bit_cnt_r + 4'd1;
                                        end
                                    end
                                end
                                S_PARITY: begin
                                    // Odd mode expects an overall XOR of 1, hence the pmode_r[1] term
                                    if (tick_cnt_r == T_S2) begin
                                        par_err_r <= parity_of(shreg_r) ^ maj_s ^ pmode_r[1];
                                    end
                                    if (tick_cnt_r == T_LAST) state_r <= S_STOP;
                                end
                                S_STOP: begin
                                    if (tick_cnt_r == T_S2) begin
                                        if (!maj_s) frm_err_r <= 1'b1;
                                        // Leave on the last sample so a back-to-back start is not missed
                                        if (stop_cnt_r == two_stop_r) begin
                                            state_r    <= S_IDLE;
                                            busy_r     <= 1'b0;
                                            tick_cnt_r <= ZERO;
                                            done_r     <= 1'b1;
                                        end
                                    end
                                    if (tick_cnt_r == T_LAST) stop_cnt_r <= 1'b1;
                                end
                                default: begin
                                    state_r <= S_IDLE;
                                    busy_r  <= 1'b0;
                                end
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    // Output word register and valid/ready handshake with overrun tracking
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            RxData    <= {MAX_BITS{1'b0}};
            RxValid   <= 1'b0;
            FrameErr  <= 1'b0;
            ParityErr <= 1'b0;
            Overrun   <= 1'b0;
        end else if (done_r) begin
            if (RxValid && !RxReady) begin
                Overrun <= 1'b1;
            end else begin
                RxData    <= shreg_r;
                FrameErr  <= frm_err_r;
                ParityErr <= par_err_r;
                RxValid   <= 1'b1;
                Overrun   <= 1'b0;
            end
        end else if (RxValid && RxReady) begin
            RxValid <= 1'b0;
            Overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Randomised and directed bench for uart_rx_cfg. Frames are built bit by bit
// from data, length, parity and stop settings; the expected word is derived
// from those settings with plain arithmetic and compared at each handshake.
module tb_uart_rx_cfg;

    localparam int OS   = 16;
    localparam int MAXB = 9;

    logic       Clk        = 1'b0;
    logic       Rst_n      = 1'b0;
    logic       Tick       = 1'b0;
    logic       RxEn       = 1'b0;
    logic       Rx         = 1'b1;
    logic [3:0] NBits      = 4'd8;
    logic [1:0] ParityMode = 2'b00;
    logic       StopBits   = 1'b0;
    logic       RxReady    = 1'b1;
    logic [8:0] RxData;
    logic       RxValid;
    logic       FrameErr;
    logic       ParityErr;
    logic       Overrun;
    logic       Busy;

    uart_rx_cfg #(.OVERSAMPLE(OS), .MAX_BITS(MAXB), .SYNC_STAGES(2)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Tick(Tick), .RxEn(RxEn), .Rx(Rx),
        .NBits(NBits), .ParityMode(ParityMode), .StopBits(StopBits),
        .RxData(RxData), .RxValid(RxValid), .RxReady(RxReady),
        .FrameErr(FrameErr), .ParityErr(ParityErr), .Overrun(Overrun), .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [8:0] data;
        logic       fe;
        logic       pe;
        logic       ov;
    } word_t;

    word_t exp_q[$];
    int    checks   = 0;
    int    failures = 0;
    int    clk_cnt  = 0;
    int    last_tick_clk = 0;
    int    rise_clk = -1000;
    int    rise_cnt = 0;
    logic  prev_valid = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge Clk) clk_cnt <= clk_cnt + 1;

    // Handshake monitor: every accepted word must match the oldest expected one
    always @(negedge Clk) begin
        prev_valid <= RxValid;
        if (RxValid && !prev_valid) begin
            rise_clk <= clk_cnt;
            rise_cnt <= rise_cnt + 1;
        end
        if (Rst_n && RxValid && RxReady) begin
            check_eq("word_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                check_eq("rx_data", 32'(RxData), 32'(exp_q[0].data));
                check_eq("frame_err", 32'(FrameErr), 32'(exp_q[0].fe));
                check_eq("parity_err", 32'(ParityErr), 32'(exp_q[0].pe));
                check_eq("overrun", 32'(Overrun), 32'(exp_q[0].ov));
                exp_q.delete(0);
            end
        end
    end

    task automatic tick_step();
        Tick = 1'b1;
        @(posedge Clk);
        #1;
        Tick = 1'b0;
        last_tick_clk = clk_cnt;
        repeat (3) @(posedge Clk);
        #1;
    endtask

    task automatic idle_ticks(input int n);
        Rx = 1'b1;
        repeat (n) tick_step();
    endtask

    task automatic check_outputs_clear(input string tag);
        check_eq({tag, "_valid"}, 32'(RxValid), 32'd0);
        check_eq({tag, "_data"}, 32'(RxData), 32'd0);
        check_eq({tag, "_fe"}, 32'(FrameErr), 32'd0);
        check_eq({tag, "_pe"}, 32'(ParityErr), 32'd0);
        check_eq({tag, "_ov"}, 32'(Overrun), 32'd0);
        check_eq({tag, "_busy"}, 32'(Busy), 32'd0);
    endtask

    // Build a frame from its settings, drive it tick by tick and, when a word
    // is expected with RxReady high, check delivery and its latency.
    task automatic send_frame(input logic [8:0] data, input int nb_in, input logic [1:0] pm,
                              input logic sb, input logic bad_par, input logic [1:0] bad_stop,
                              input int glitch_bit, input int glitch_sub,
                              input int abort_step, input logic abort_rst, input logic expect_word);
        int         n;
        int         ones;
        int         nbits_tot;
        int         final_step;
        int         tick_at_final;
        logic       line_bits[0:15];
        logic       has_par;
        logic       pbit;
        logic       fe;
        logic [8:0] exp_data;
        word_t      w;
        n = (nb_in < 5) ? 5 : ((nb_in > MAXB) ? MAXB : nb_in);
        ones = 0;
        exp_data = 9'h000;
        line_bits[0] = 1'b0;
        for (int i = 0; i < n; i++) begin
            line_bits[1 + i] = data[i];
            exp_data[i] = data[i];
            ones += int'(data[i]);
        end
        nbits_tot = 1 + n;
        has_par = (pm == 2'b01) || (pm == 2'b10);
        if (has_par) begin
            pbit = ((pm == 2'b01) ? (ones % 2 == 1) : (ones % 2 == 0)) ^ bad_par;
            line_bits[nbits_tot] = pbit;
            nbits_tot++;
        end
        fe = 1'b0;
        for (int k = 0; k < (sb ? 2 : 1); k++) begin
            line_bits[nbits_tot] = ~bad_stop[k];
            fe = fe | bad_stop[k];
            nbits_tot++;
        end
        if (expect_word) begin
            w.data = exp_data;
            w.fe   = fe;
            w.pe   = has_par & bad_par;
            w.ov   = 1'b0;
            exp_q.push_back(w);
        end
        final_step = OS * (nbits_tot - 1) + OS / 2 + 2;
        tick_at_final = -1;
        NBits = 4'(nb_in);
        ParityMode = pm;
        StopBits = sb;
        for (int s = 0; s < nbits_tot * OS; s++) begin
            if (s == abort_step) begin
                Rx = 1'b1;
                if (abort_rst) begin
                    Rst_n = 1'b0;
                    @(posedge Clk);
                    #1;
                    Rst_n = 1'b1;
                    check_outputs_clear("reset_mid");
                end else begin
                    RxEn = 1'b0;
                    tick_step();
                    tick_step();
                    RxEn = 1'b1;
                end
                break;
            end
            // Settings must have been captured at the start edge
            if (s == OS) begin
                NBits = 4'($urandom_range(0, 15));
                ParityMode = 2'($urandom_range(0, 3));
                StopBits = 1'($urandom_range(0, 1));
            end
            Rx = line_bits[s / OS];
            if (glitch_bit >= 0 && (s / OS) == 1 + (glitch_bit % n) && (s % OS) == glitch_sub) Rx = ~Rx;
            tick_step();
            if (s == final_step) tick_at_final = last_tick_clk;
        end
        Rx = 1'b1;
        if (expect_word) begin
            check_eq("latency", 32'(rise_clk - tick_at_final), 32'd1);
            check_eq("word_taken", 32'(exp_q.size()), 32'd0);
        end
    endtask

    initial begin
        int    rc;
        word_t w;
        repeat (3) @(posedge Clk);
        #1;
        check_outputs_clear("reset");
        Rst_n = 1'b1;
        RxEn = 1'b1;
        RxReady = 1'b1;
        idle_ticks(4);

        // 8N1 0xA5
        send_frame(9'h0A5, 8, 2'b00, 1'b0, 1'b0, 2'b00, -1, 0, -1, 1'b0, 1'b1);
        idle_ticks(2);
        // 7E1 0x41 with wrong then right parity; 9O2 0x1FF
        send_frame(9'h041, 7, 2'b01, 1'b0, 1'b1, 2'b00, -1, 0, -1, 1'b0, 1'b1);
        idle_ticks(2);
        send_frame(9'h041, 7, 2'b01, 1'b0, 1'b0, 2'b00, -1, 0, -1, 1'b0, 1'b1);
        idle_ticks(2);
        send_frame(9'h1FF, 9, 2'b10, 1'b1, 1'b0, 2'b00, -1, 0, -1, 1'b0, 1'b1);
        idle_ticks(2);
        // Second of two stop bits low
        send_frame(9'h0C3, 8, 2'b00, 1'b1, 1'b0, 2'b10, -1, 0, -1, 1'b0, 1'b1);
        idle_ticks(2);
        // Break: whole frame low, then line stays low
        send_frame(9'h000, 8, 2'b00, 1'b0, 1'b0, 2'b01, -1, 0, -1, 1'b0, 1'b1);
        rc = rise_cnt;
        Rx = 1'b0;
        repeat (40) tick_step();
        check_eq("break_no_restart", 32'(rise_cnt - rc), 32'd0);
        check_eq("break_busy", 32'(Busy), 32'd0);
        idle_ticks(2);
        send_frame(9'h096, 8, 2'b00, 1'b0, 1'b0, 2'b00, -1, 0, -1, 1'b0, 1'b1);
        idle_ticks(2);

        // False start: 5 ticks low
        rc = rise_cnt;
        for (int s = 0; s < OS; s++) begin
            Rx = (s < 5) ? 1'b0 : 1'b1;
            tick_step();
            if (s == 9) check_eq("false_start_busy_hi", 32'(Busy), 32'd1);
            if (s == 10) check_eq("false_start_busy_lo", 32'(Busy), 32'd0);
        end
        idle_ticks(4);
        check_eq("false_start_no_word", 32'(rise_cnt - rc), 32'd0);

        // One-tick glitch in the middle of data bit 3
        send_frame(9'h0A5, 8, 2'b00, 1'b0, 1'b0, 2'b00, 3, 8, -1, 1'b0, 1'b1);
        idle_ticks(2);
        // NBits = 3 behaves as 5
        send_frame(9'h1F5, 3, 2'b00, 1'b0, 1'b0, 2'b00, -1, 0, -1, 1'b0, 1'b1);
        idle_ticks(2);

        // Overrun: two back-to-back frames with nobody accepting
        RxReady = 1'b0;
        send_frame(9'h011, 8, 2'b00, 1'b0, 1'b0, 2'b00, -1, 0, -1, 1'b0, 1'b0);
        send_frame(9'h022, 8, 2'b00, 1'b0, 1'b0, 2'b00, -1, 0, -1, 1'b0, 1'b0);
        idle_ticks(2);
        check_eq("ovr_valid", 32'(RxValid), 32'd1);
        check_eq("ovr_data", 32'(RxData), 32'h011);
        check_eq("ovr_flag", 32'(Overrun), 32'd1);
        w.data = 9'h011;
        w.fe = 1'b0;
        w.pe = 1'b0;
        w.ov = 1'b1;
        exp_q.push_back(w);
        RxReady = 1'b1;
        @(posedge Clk);
        #1;
        RxReady = 1'b0;
        check_eq("ovr_accept_valid", 32'(RxValid), 32'd0);
        check_eq("ovr_accept_flag", 32'(Overrun), 32'd0);
        check_eq("ovr_word_taken", 32'(exp_q.size()), 32'd0);

        // Reset in DATA while a word with FrameErr is pending
        send_frame(9'h05A, 8, 2'b00, 1'b0, 1'b0, 2'b01, -1, 0, -1, 1'b0, 1'b0);
        idle_ticks(2);
        check_eq("pending_fe", 32'(FrameErr), 32'd1);
        send_frame(9'h0FF, 8, 2'b00, 1'b0, 1'b0, 2'b00, -1, 0, 3 * OS + 4, 1'b1, 1'b0);
        RxReady = 1'b1;
        idle_ticks(2);
        send_frame(9'h03C, 8, 2'b00, 1'b0, 1'b0, 2'b00, -1, 0, -1, 1'b0, 1'b1);
        idle_ticks(2);

        // RxEn dropped during DATA
        rc = rise_cnt;
        send_frame(9'h0F0, 8, 2'b00, 1'b0, 1'b0, 2'b00, -1, 0, 4 * OS + 2, 1'b0, 1'b0);
        idle_ticks(OS * 12);
        check_eq("rxen_abort_no_word", 32'(rise_cnt - rc), 32'd0);
        check_eq("rxen_abort_busy", 32'(Busy), 32'd0);

        // Randomised frames
        for (int f = 0; f < 25; f++) begin
            logic [1:0] bs;
            int         gb;
            bs = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            gb = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 8)) : -1;
            send_frame(9'($urandom), int'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), bs,
                       gb, int'($urandom_range(7, 9)), -1, 1'b0, 1'b1);
            idle_ticks(2);
        end

        check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
